// File: rtl/mod_mem_bus_bridge_if.sv
// ---------------------------------------------------------------------------
// mod_mem_bus_bridge_if
// Purpose : Avalon-MM-style main-memory bus between the cache bridge (master)
//           and the memory slave.
// Signals :
//   address / writedata / byteenable  master -> slave  command payload
//   read / write                      master -> slave  command strobes
//   waitrequest                       slave  -> master stall; command accepted
//                                                      in a cycle it is low
//   readdatavalid / readdata          slave  -> master read response
// ---------------------------------------------------------------------------
interface mod_mem_bus_bridge_if #(
    parameter int XLEN     = 32,
    parameter int BE_WIDTH = 4
) ();
    logic [XLEN-1:0]     address;
    logic [XLEN-1:0]     writedata;
    logic [BE_WIDTH-1:0] byteenable;
    logic                read;
    logic                write;
    logic                waitrequest;
    logic                readdatavalid;
    logic [XLEN-1:0]     readdata;

    modport master (
        output address, writedata, byteenable, read, write,
        input  waitrequest, readdatavalid, readdata
    );

    modport slave (
        input  address, writedata, byteenable, read, write,
        output waitrequest, readdatavalid, readdata
    );
endinterface

// File: rtl/mod_mem_bus_bridge.sv
// ---------------------------------------------------------------------------
// mod_mem_bus_bridge
// Purpose : Takes the cache's single-word memory request (level-held
//           read/write) and runs it as one Avalon-MM-style bus transaction.
//           Completion is reported with a one-cycle memory_operation_stb_o.
//           A timeout guard forces completion (with bus_error_o) when the
//           slave never accepts the command or never returns read data.
// Ports   :
//   clk_i, rst_i               clock (rising edge), async active-high reset
//   memory_address_i           request address from cache
//   memory_writedata_i         write data from cache
//   memory_byteenable_i        byte lanes
//   memory_read_i/_write_i     request levels, held until stb
//   memory_readdata_o          read result; holds its value between pulses
//   memory_operation_stb_o     one-cycle completion pulse
//   bus_error_o                high with stb when the access timed out
//   bus                        master side of the memory bus (all outputs
//                              registered)
// Note    : TIMEOUT_BITS must satisfy 2**TIMEOUT_BITS > TIMEOUT_CYCLES.
// ---------------------------------------------------------------------------
module mod_mem_bus_bridge #(
    parameter int XLEN           = 32,
    parameter int BE_WIDTH       = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_BITS   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [XLEN-1:0]      memory_address_i,
    input  logic [XLEN-1:0]      memory_writedata_i,
    input  logic [BE_WIDTH-1:0]  memory_byteenable_i,
    input  logic                 memory_read_i,
    input  logic                 memory_write_i,
    output logic [XLEN-1:0]      memory_readdata_o,
    output logic                 memory_operation_stb_o,
    output logic                 bus_error_o,
    mod_mem_bus_bridge_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Counter value in the last allowed REQ/WAIT_RD cycle: the bridge spends
    // exactly TIMEOUT_CYCLES cycles there before a forced completion.
    localparam logic [TIMEOUT_BITS-1:0] TIMEOUT_LAST = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_BITS-1:0] CNT_MAX      = {TIMEOUT_BITS{1'b1}};

    state_t              state_r;
    logic                is_write_r;
    logic [TIMEOUT_BITS-1:0] timeout_cnt_r;
    logic [XLEN-1:0]     bus_address_r;
    logic [XLEN-1:0]     bus_writedata_r;
    logic [BE_WIDTH-1:0] bus_byteenable_r;
    logic                bus_read_r;
    logic                bus_write_r;
    logic [XLEN-1:0]     readdata_r;
    logic                stb_r;
    logic                error_r;
    logic                timeout_hit_s;

    // Saturating increment so the counter can never wrap back into range.
    function automatic logic [TIMEOUT_BITS-1:0] sat_inc(input logic [TIMEOUT_BITS-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + TIMEOUT_BITS'(1);
        end
    endfunction

    // Timeout fires at the end of the last allowed waiting cycle.
    always_comb begin
        timeout_hit_s = 1'b0;
        if (timeout_cnt_r >= TIMEOUT_LAST) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Bridge FSM with all outputs registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r          <= ST_IDLE;
            is_write_r       <= 1'b0;
            timeout_cnt_r    <= '0;
            bus_address_r    <= '0;
            bus_writedata_r  <= '0;
            bus_byteenable_r <= '0;
            bus_read_r       <= 1'b0;
            bus_write_r      <= 1'b0;
            readdata_r       <= '0;
            stb_r            <= 1'b0;
            error_r          <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    stb_r   <= 1'b0;
                    error_r <= 1'b0;
                    if (memory_write_i || memory_read_i) begin
                        // Write wins when both are requested.
                        bus_address_r    <= memory_address_i;
                        bus_writedata_r  <= memory_writedata_i;
                        bus_byteenable_r <= memory_byteenable_i;
                        bus_write_r      <= memory_write_i;
                        bus_read_r       <= ~memory_write_i;
                        is_write_r       <= memory_write_i;
                        timeout_cnt_r    <= '0;
                        state_r          <= ST_REQ;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_REQ: begin
                    timeout_cnt_r <= sat_inc(timeout_cnt_r);
                    // Acceptance beats a coincident timeout: the slave took it.
                    if (!bus.waitrequest) begin
                        bus_read_r  <= 1'b0;
                        bus_write_r <= 1'b0;
                        if (is_write_r) begin
                            readdata_r <= '0;
                            error_r    <= 1'b0;
                            stb_r      <= 1'b1;
                            state_r    <= ST_DONE;
                        end else begin
                            state_r <= ST_WAIT_RD;
                        end
                    end else if (timeout_hit_s) begin
                        bus_read_r  <= 1'b0;
                        bus_write_r <= 1'b0;
                        readdata_r  <= '0;
                        error_r     <= 1'b1;
                        stb_r       <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end

                ST_WAIT_RD: begin
                    timeout_cnt_r <= sat_inc(timeout_cnt_r);
                    if (bus.readdatavalid) begin
                        readdata_r <= bus.readdata;
                        error_r    <= 1'b0;
                        stb_r      <= 1'b1;
                        state_r    <= ST_DONE;
                    end else if (timeout_hit_s) begin
                        readdata_r <= '0;
                        error_r    <= 1'b1;
                        stb_r      <= 1'b1;
                        state_r    <= ST_DONE;
                    end else begin
                        state_r <= ST_WAIT_RD;
                    end
                end

                ST_DONE: begin
                    // The requester drops its level on this edge, so the
                    // request is only looked at again from IDLE.
                    stb_r   <= 1'b0;
                    error_r <= 1'b0;
                    state_r <= ST_IDLE;
                end

                default: begin
                    bus_read_r  <= 1'b0;
                    bus_write_r <= 1'b0;
                    stb_r       <= 1'b0;
                    error_r     <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.address            = bus_address_r;
    assign bus.writedata          = bus_writedata_r;
    assign bus.byteenable         = bus_byteenable_r;
    assign bus.read               = bus_read_r;
    assign bus.write              = bus_write_r;
    assign memory_readdata_o      = readdata_r;
    assign memory_operation_stb_o = stb_r;
    assign bus_error_o            = error_r;

endmodule

// File: tb/tb_mod_mem_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_mod_mem_bus_bridge
// Purpose : Directed self-checking bench for mod_mem_bus_bridge. The bench
//           plays both the cache (memory_* side) and the bus slave. Inputs
//           change 1 time unit after a rising edge; outputs are sampled on
//           the falling edge. "Cycle n" is the cycle after the n-th edge
//           following the one on which the request is first seen.
// ---------------------------------------------------------------------------
module tb_mod_mem_bus_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] memory_address_i;
    logic [31:0] memory_writedata_i;
    logic [3:0]  memory_byteenable_i;
    logic        memory_read_i;
    logic        memory_write_i;
    logic [31:0] memory_readdata_o;
    logic        memory_operation_stb_o;
    logic        bus_error_o;

    int n_cmp = 0;
    int n_err = 0;

    mod_mem_bus_bridge_if #(.XLEN(32), .BE_WIDTH(4)) bif ();

    mod_mem_bus_bridge #(
        .XLEN(32), .BE_WIDTH(4), .TIMEOUT_CYCLES(8), .TIMEOUT_BITS(4)
    ) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .memory_address_i       (memory_address_i),
        .memory_writedata_i     (memory_writedata_i),
        .memory_byteenable_i    (memory_byteenable_i),
        .memory_read_i          (memory_read_i),
        .memory_write_i         (memory_write_i),
        .memory_readdata_o      (memory_readdata_o),
        .memory_operation_stb_o (memory_operation_stb_o),
        .bus_error_o            (bus_error_o),
        .bus                    (bif.master)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        memory_address_i = 32'h0; memory_writedata_i = 32'h0; memory_byteenable_i = 4'h0;
        memory_read_i = 1'b0; memory_write_i = 1'b0;
        bif.waitrequest = 1'b0; bif.readdatavalid = 1'b0; bif.readdata = 32'h0;
        smp();
        n_cmp++;
        if ({memory_operation_stb_o, bus_error_o, bif.read, bif.write} !== 4'b0000) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 0000", {memory_operation_stb_o, bus_error_o, bif.read, bif.write});
        end
        n_cmp++;
        if ({memory_readdata_o, bif.address, bif.writedata, bif.byteenable} !== 100'h0) begin
            n_err++; $display("FAIL reset_data: got %h want 0", {memory_readdata_o, bif.address, bif.writedata, bif.byteenable});
        end
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_write();
        tick();
        memory_write_i = 1'b1; memory_address_i = 32'h100;
        memory_writedata_i = 32'hDEADBEEF; memory_byteenable_i = 4'hF;
        bif.waitrequest = 1'b0;
        smp();
        n_cmp++;
        if (bif.write !== 1'b0) begin n_err++; $display("FAIL wr_c0_cmd: got %b want 0", bif.write); end
        tick(); smp();
        n_cmp++;
        if ({bif.write, bif.read, bif.address, bif.writedata, bif.byteenable, memory_operation_stb_o} !== {1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0}) begin
            n_err++; $display("FAIL wr_c1_cmd: got w%b r%b a%h d%h be%h stb%b want w1 r0 a100 dDEADBEEF beF stb0",
                bif.write, bif.read, bif.address, bif.writedata, bif.byteenable, memory_operation_stb_o);
        end
        tick(); smp();
        n_cmp++;
        if ({memory_operation_stb_o, bus_error_o, bif.write, memory_readdata_o} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            n_err++; $display("FAIL wr_c2_stb: got stb%b err%b w%b rd%h want stb1 err0 w0 rd0",
                memory_operation_stb_o, bus_error_o, bif.write, memory_readdata_o);
        end
        tick();
        memory_write_i = 1'b0;
        smp();
        n_cmp++;
        if ({memory_operation_stb_o, bif.write} !== 2'b00) begin
            n_err++; $display("FAIL wr_c3_idle: got %b want 00", {memory_operation_stb_o, bif.write});
        end
    endtask

    task automatic test_read_wait();
        int bad;
        bad = 0;
        tick();
        memory_read_i = 1'b1; memory_address_i = 32'h200; bif.waitrequest = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 2) memory_address_i = 32'h999;   // must not reach the bus
            if (c == 4) bif.waitrequest = 1'b0;
            smp();
            if (bif.read !== 1'b1 || bif.address !== 32'h200) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL rd_hold: got %0d bad cycles want 0", bad); end
        tick(); smp();   // cycle 5: WAIT_RD
        n_cmp++;
        if ({bif.read, memory_operation_stb_o} !== 2'b00) begin
            n_err++; $display("FAIL rd_c5: got %b want 00", {bif.read, memory_operation_stb_o});
        end
        tick();          // cycle 6: data returned
        bif.readdatavalid = 1'b1; bif.readdata = 32'h12345678;
        smp();
        tick();          // cycle 7: completion
        bif.readdatavalid = 1'b0; bif.readdata = 32'h0;
        smp();
        n_cmp++;
        if ({memory_operation_stb_o, bus_error_o, memory_readdata_o} !== {1'b1, 1'b0, 32'h12345678}) begin
            n_err++; $display("FAIL rd_c7_stb: got stb%b err%b rd%h want stb1 err0 rd12345678",
                memory_operation_stb_o, bus_error_o, memory_readdata_o);
        end
        tick();
        memory_read_i = 1'b0;
        smp();
        n_cmp++;
        if ({memory_operation_stb_o, memory_readdata_o} !== {1'b0, 32'h12345678}) begin
            n_err++; $display("FAIL rd_hold_data: got stb%b rd%h want stb0 rd12345678", memory_operation_stb_o, memory_readdata_o);
        end
    endtask

    // accept_now=0: slave stalls forever; accept_now=1: accepts, never answers.
    task automatic test_timeout(input bit accept_now, input logic [31:0] addr);
        int bad;
        bad = 0;
        tick();
        memory_read_i = 1'b1; memory_address_i = addr; bif.waitrequest = ~accept_now;
        for (int c = 1; c <= 8; c++) begin
            tick(); smp();
            if (memory_operation_stb_o !== 1'b0) bad++;
            if (!accept_now && bif.read !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL to_span acc%0d: got %0d bad cycles want 0", accept_now, bad); end
        tick(); smp();   // cycle 9: forced completion
        n_cmp++;
        if ({memory_operation_stb_o, bus_error_o, bif.read, memory_readdata_o} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
            n_err++; $display("FAIL to_stb acc%0d: got stb%b err%b r%b rd%h want stb1 err1 r0 rd0",
                accept_now, memory_operation_stb_o, bus_error_o, bif.read, memory_readdata_o);
        end
        tick();
        memory_read_i = 1'b0; bif.waitrequest = 1'b0;
        // Follow-up read completes normally.
        tick();
        memory_read_i = 1'b1; memory_address_i = addr + 32'h4;
        tick();          // cycle 1: accepted immediately
        tick();          // cycle 2: data
        bif.readdatavalid = 1'b1; bif.readdata = 32'hA5A50001;
        tick();          // cycle 3: completion
        bif.readdatavalid = 1'b0;
        smp();
        n_cmp++;
        if ({memory_operation_stb_o, bus_error_o, memory_readdata_o} !== {1'b1, 1'b0, 32'hA5A50001}) begin
            n_err++; $display("FAIL to_next acc%0d: got stb%b err%b rd%h want stb1 err0 rdA5A50001",
                accept_now, memory_operation_stb_o, bus_error_o, memory_readdata_o);
        end
        tick();
        memory_read_i = 1'b0;
    endtask

    task automatic test_both();
        tick();
        memory_read_i = 1'b1; memory_write_i = 1'b1; memory_address_i = 32'h400;
        memory_writedata_i = 32'hCAFEF00D; memory_byteenable_i = 4'h3;
        tick(); smp();
        n_cmp++;
        if ({bif.write, bif.read, bif.byteenable, bif.writedata} !== {1'b1, 1'b0, 4'h3, 32'hCAFEF00D}) begin
            n_err++; $display("FAIL both_cmd: got w%b r%b be%h d%h want w1 r0 be3 dCAFEF00D",
                bif.write, bif.read, bif.byteenable, bif.writedata);
        end
        tick(); smp();
        n_cmp++;
        if ({memory_operation_stb_o, bus_error_o, memory_readdata_o} !== {1'b1, 1'b0, 32'h0}) begin
            n_err++; $display("FAIL both_stb: got stb%b err%b rd%h want stb1 err0 rd0",
                memory_operation_stb_o, bus_error_o, memory_readdata_o);
        end
        tick();
        memory_read_i = 1'b0; memory_write_i = 1'b0;
    endtask

    task automatic test_async_reset();
        int bad;
        bad = 0;
        // Reset while the command is stalled in REQ.
        tick();
        memory_read_i = 1'b1; memory_address_i = 32'h500; bif.waitrequest = 1'b1;
        tick(); smp();
        #1 rst_i = 1'b1;
        #1;
        n_cmp++;
        if ({bif.read, bif.address} !== {1'b0, 32'h0}) begin
            n_err++; $display("FAIL arst_req: got r%b a%h want r0 a0", bif.read, bif.address);
        end
        tick();
        rst_i = 1'b0; memory_read_i = 1'b0; bif.waitrequest = 1'b0;
        // Reset while waiting for read data.
        tick();
        memory_read_i = 1'b1; memory_address_i = 32'h580;
        tick();          // cycle 1: accepted
        tick(); smp();   // cycle 2: WAIT_RD
        #1 rst_i = 1'b1;
        #1;
        n_cmp++;
        if ({bif.read, memory_operation_stb_o, bif.address} !== {1'b0, 1'b0, 32'h0}) begin
            n_err++; $display("FAIL arst_wait: got r%b stb%b a%h want r0 stb0 a0", bif.read, memory_operation_stb_o, bif.address);
        end
        tick();
        memory_read_i = 1'b0;
        tick();
        rst_i = 1'b0;
        tick();          // late data arriving in IDLE
        bif.readdatavalid = 1'b1; bif.readdata = 32'hFFFFFFFF;
        tick();
        bif.readdatavalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            smp();
            if ({memory_operation_stb_o, bif.read, memory_readdata_o} !== {1'b0, 1'b0, 32'h0}) bad++;
            tick();
        end
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL arst_late_rdv: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_back_to_back();
        tick();
        memory_read_i = 1'b1; memory_address_i = 32'h600; bif.waitrequest = 1'b0;
        tick();          // c1: accepted
        tick();          // c2: data
        bif.readdatavalid = 1'b1; bif.readdata = 32'h11111111;
        tick();          // c3: stb
        bif.readdatavalid = 1'b0;
        smp();
        n_cmp++;
        if ({memory_operation_stb_o, memory_readdata_o} !== {1'b1, 32'h11111111}) begin
            n_err++; $display("FAIL b2b_stb1: got stb%b rd%h want stb1 rd11111111", memory_operation_stb_o, memory_readdata_o);
        end
        tick();          // c4: IDLE, new request still held; stray rdv
        memory_address_i = 32'h604;
        bif.readdatavalid = 1'b1; bif.readdata = 32'h22222222;
        smp();
        n_cmp++;
        if ({bif.read, memory_operation_stb_o} !== 2'b00) begin
            n_err++; $display("FAIL b2b_c4: got %b want 00", {bif.read, memory_operation_stb_o});
        end
        tick();          // c5: second command
        bif.readdatavalid = 1'b0;
        smp();
        n_cmp++;
        if ({bif.read, bif.address, memory_operation_stb_o, memory_readdata_o} !== {1'b1, 32'h604, 1'b0, 32'h11111111}) begin
            n_err++; $display("FAIL b2b_c5: got r%b a%h stb%b rd%h want r1 a604 stb0 rd11111111",
                bif.read, bif.address, memory_operation_stb_o, memory_readdata_o);
        end
        tick();          // c6: data
        bif.readdatavalid = 1'b1; bif.readdata = 32'h33333333;
        tick();          // c7: stb
        bif.readdatavalid = 1'b0;
        smp();
        n_cmp++;
        if ({memory_operation_stb_o, bus_error_o, memory_readdata_o} !== {1'b1, 1'b0, 32'h33333333}) begin
            n_err++; $display("FAIL b2b_stb2: got stb%b err%b rd%h want stb1 err0 rd33333333",
                memory_operation_stb_o, bus_error_o, memory_readdata_o);
        end
        tick();
        memory_read_i = 1'b0;
        smp();
        n_cmp++;
        if (memory_operation_stb_o !== 1'b0) begin
            n_err++; $display("FAIL b2b_end: got stb%b want stb0", memory_operation_stb_o);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_timeout(1'b0, 32'h300);
        test_timeout(1'b1, 32'h340);
        test_both();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit reached want bench completion");
        $fatal(1, "watchdog");
    end

endmodule
